cv32e40x_fencei_sequencer: RTL

Sequences execution of a fence.i instruction that has reached WB. It drains the LSU, then runs the fencei_flush_req/ack handshake with the external cache/prefetch system. It then requests a pipeline kill and a refetch at the instruction after the fence.i. The block sits beside the main controller FSM, which consumes its halt, kill, pc_set and retire outputs.

---
 rtl/cv32e40x_pkg.sv | 15 +
 rtl/cv32e40x_fencei_sequencer.sv | 97 +++++++++
 2 files changed

// File: rtl/cv32e40x_pkg.sv
// Shared core types and constants used by the fence.i sequencer.
package cv32e40x_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DRAIN    = 2'd1,
    REQ      = 2'd2,
    REDIRECT = 2'd3
  } fencei_state_e;

  // Refetch increment past a 16-bit or 32-bit fence.i encoding
  localparam int unsigned FENCEI_PC_INCR_16 = 2;
  localparam int unsigned FENCEI_PC_INCR_32 = 4;

endpackage

// File: rtl/cv32e40x_fencei_sequencer.sv
// Sequences a fence.i in WB: drain LSU, flush req/ack handshake, then kill/refetch/retire.
module cv32e40x_fencei_sequencer
  import cv32e40x_pkg::*;
#(
  parameter int unsigned PC_WIDTH       = 32,
  parameter int unsigned WAIT_CNT_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      fencei_wb_i,
  input  logic [PC_WIDTH-1:0]       fencei_pc_wb_i,
  input  logic                      fencei_instr_compressed_i,
  input  logic                      kill_wb_i,
  input  logic                      lsu_busy_i,
  input  logic                      lsu_write_buffer_empty_i,
  output logic                      fencei_flush_req_o,
  input  logic                      fencei_flush_ack_i,
  output logic                      halt_wb_o,
  output logic                      kill_pipe_o,
  output logic                      pc_set_o,
  output logic [PC_WIDTH-1:0]       pc_o,
  output logic                      retire_o,
  output logic                      busy_o,
  output logic [WAIT_CNT_WIDTH-1:0] drain_cycles_o
);

  fencei_state_e       state_q;
  fencei_state_e       state_d;
  logic                detect_c;
  logic                halt_q;
  logic [PC_WIDTH-1:0] pc_incr_c;

  assign detect_c  = (state_q == IDLE) && fencei_wb_i && !kill_wb_i;
  assign pc_incr_c = fencei_instr_compressed_i ? PC_WIDTH'(FENCEI_PC_INCR_16)
                                               : PC_WIDTH'(FENCEI_PC_INCR_32);

  // Hold WB in the detect cycle already so the fence.i cannot retire early
  assign halt_wb_o = halt_q | detect_c;

  // Next-state logic; a WB kill only aborts while still draining
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (detect_c) state_d = DRAIN;
      end
      DRAIN: begin
        if (kill_wb_i)                                      state_d = IDLE;
        else if (!lsu_busy_i && lsu_write_buffer_empty_i)   state_d = REQ;
      end
      REQ: begin
        if (fencei_flush_req_o && fencei_flush_ack_i) state_d = REDIRECT;
      end
      REDIRECT: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // State, refetch target, drain counter and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q            <= IDLE;
      halt_q             <= 1'b0;
      fencei_flush_req_o <= 1'b0;
      kill_pipe_o        <= 1'b0;
      pc_set_o           <= 1'b0;
      retire_o           <= 1'b0;
      busy_o             <= 1'b0;
      pc_o               <= '0;
      drain_cycles_o     <= '0;
    end else begin
      state_q            <= state_d;
      halt_q             <= (state_d == DRAIN) || (state_d == REQ);
      fencei_flush_req_o <= (state_d == REQ);
      kill_pipe_o        <= (state_d == REDIRECT);
      pc_set_o           <= (state_d == REDIRECT);
      retire_o           <= (state_d == REDIRECT);
      busy_o             <= (state_d != IDLE);
      if (detect_c) begin
        pc_o           <= fencei_pc_wb_i + pc_incr_c;
        drain_cycles_o <= '0;
      end else if ((state_q == DRAIN) && (drain_cycles_o != '1)) begin
        drain_cycles_o <= drain_cycles_o + WAIT_CNT_WIDTH'(1);
      end
    end
  end

  a_pulse_equal: assert property (@(posedge clk) disable iff (!rst_n)
    (kill_pipe_o == pc_set_o) && (pc_set_o == retire_o));

  a_req_held_until_ack: assert property (@(posedge clk) disable iff (!rst_n)
    $fell(fencei_flush_req_o) |-> $past(fencei_flush_ack_i));

  a_idle_halt: assert property (@(posedge clk) disable iff (!rst_n)
    !busy_o |-> (halt_wb_o == (fencei_wb_i & ~kill_wb_i)));

endmodule
